// File: rtl/dense_param_loader.sv
// Dense-layer parameter loader.
// Accepts a valid/ready word stream and fills a registered weight matrix
// followed by a bias vector. The stream order is weights row-major, then biases.
// A complete set must end with s_last on exactly the final word; any other
// placement of s_last, or a missing one, parks the loader in ERR until clear.
module dense_param_loader #(
  parameter int DATA_W = 8,
  parameter int D1     = 4,
  parameter int D2     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_W-1:0]                     s_data,
  input  logic                                  s_last,
  input  logic                                  clear,
  output logic [D1-1:0][D2-1:0][DATA_W-1:0]     weights_o,
  output logic [D2-1:0][DATA_W-1:0]             biases_o,
  output logic                                  params_valid,
  output logic                                  busy,
  output logic                                  err
);

  localparam int NW = D1 * D2;
  localparam int N  = NW + D2;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_W_IDX = CW'(NW - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    DONE,
    ERR
  } state_t;

  state_t        state;
  state_t        xfer_state;
  logic [CW-1:0] cnt;
  logic          xfer;
  logic          loading;

  // Where the FSM lands after accepting the word at position idx.
  // s_last is only legal on the final word, and the final word needs it.
  function automatic state_t after_xfer(input logic [CW-1:0] idx, input logic last);
    state_t r;
    if (last != (idx == LAST_IDX)) begin
      r = ERR;
    end else if (idx == LAST_IDX) begin
      r = DONE;
    end else if (idx < LAST_W_IDX) begin
      r = LOAD_W;
    end else begin
      r = LOAD_B;
    end
    return r;
  endfunction

  assign loading    = (state == IDLE) || (state == LOAD_W) || (state == LOAD_B);
  assign s_ready    = loading && !clear;
  assign xfer       = s_valid && s_ready;
  assign xfer_state = after_xfer(cnt, s_last);

  // Control FSM: state, word counter and the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      params_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      params_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else if (xfer) begin
      state        <= xfer_state;
      params_valid <= (xfer_state == DONE);
      err          <= (xfer_state == ERR);
      busy         <= (xfer_state == LOAD_W) || (xfer_state == LOAD_B);
      if ((xfer_state == LOAD_W) || (xfer_state == LOAD_B)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Parameter storage: the accepted word goes to the slot selected by the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      weights_o <= '0;
      biases_o  <= '0;
    end else if (xfer) begin
      for (int i = 0; i < D1; i++) begin
        for (int j = 0; j < D2; j++) begin
          if (cnt == CW'(i * D2 + j)) begin
            weights_o[i][j] <= s_data;
          end
        end
      end
      for (int j = 0; j < D2; j++) begin
        if (cnt == CW'(NW + j)) begin
          biases_o[j] <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_param_loader.sv
// Testbench for dense_param_loader with D1=2, D2=3 (nine-word parameter sets).
// A stimulus process streams parameter sets and queues the expected outcome;
// a monitor pops and checks whenever the loader reports DONE or ERR.
module tb_dense_param_loader;

  localparam int DW = 8;
  localparam int D1 = 2;
  localparam int D2 = 3;
  localparam int N  = D1 * D2 + D2;

  typedef logic [D1-1:0][D2-1:0][DW-1:0] wmat_t;
  typedef logic [D2-1:0][DW-1:0]         bvec_t;

  typedef struct packed {
    logic  is_err;
    wmat_t w;
    bvec_t b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          clear;
  wmat_t         weights_o;
  bvec_t         biases_o;
  logic          params_valid;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem  [N];
  logic [7:0] stim [N];
  exp_t       sbq  [$];
  exp_t       monE;
  logic       prevPv  = 1'b0;
  logic       prevErr = 1'b0;

  dense_param_loader #(.DATA_W(DW), .D1(D1), .D2(D2)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .clear        (clear),
    .weights_o    (weights_o),
    .biases_o     (biases_o),
    .params_valid (params_valid),
    .busy         (busy),
    .err          (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference view of the weight matrix built from the flat word memory.
  function automatic wmat_t modelW();
    wmat_t r;
    for (int i = 0; i < D1; i++)
      for (int j = 0; j < D2; j++)
        r[i][j] = mem[i * D2 + j];
    return r;
  endfunction

  // Reference view of the bias vector.
  function automatic bvec_t modelB();
    bvec_t r;
    for (int j = 0; j < D2; j++)
      r[j] = mem[D1 * D2 + j];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkArrays(input string name);
    checkOutput({name, "_weights"}, weights_o, modelW());
    checkOutput({name, "_biases"}, biases_o, modelB());
  endtask

  // Monitor: whenever DONE or ERR is newly reported, compare against the queue head.
  always @(negedge clk) begin
    if ((params_valid === 1'b1 && prevPv !== 1'b1) || (err === 1'b1 && prevErr !== 1'b1)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got valid=%0b err=%0b expected no result", params_valid, err);
      end else begin
        monE = sbq.pop_front();
        checkOutput("result_err", err, monE.is_err);
        checkOutput("result_valid", params_valid, !monE.is_err);
        checkOutput("result_weights", weights_o, monE.w);
        checkOutput("result_biases", biases_o, monE.b);
        checkOutput("result_busy", busy, 1'b0);
      end
    end
    prevPv  = params_valid;
    prevErr = err;
  end

  // Streams stim[0..count-1]; s_last rides on word lastAt (-1 means never).
  // If the stream reaches a terminal word, the expected outcome is queued first.
  task automatic applyStimulus(input int count, input int lastAt, input int gapPct);
    int   k;
    int   waited;
    bit   terminal;
    exp_t e;
    k        = (lastAt >= 0) ? lastAt : N - 1;
    terminal = (count == k + 1);
    for (int idx = 0; idx < count; idx++) mem[idx] = stim[idx];
    e.is_err = (lastAt != N - 1);
    e.w      = modelW();
    e.b      = modelB();
    if (terminal) sbq.push_back(e);
    for (int idx = 0; idx < count; idx++) begin
      @(negedge clk);
      #1;
      if (idx > 0) checkOutput("busy_during_load", busy, 1'b1);
      while ($urandom_range(99) < gapPct) begin
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        if (idx > 0) checkOutput("busy_during_gap", busy, 1'b1);
      end
      s_valid = 1'b1;
      s_data  = stim[idx];
      s_last  = (idx == lastAt);
      #1;
      waited = 0;
      while (s_ready !== 1'b1 && waited < 20) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (s_ready !== 1'b1) begin
        total++;
        bad++;
        $display("[TB] FAIL handshake_timeout: got s_ready=%0b expected 1 for word %0d", s_ready, idx);
      end
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (terminal) begin
      checkOutput("final_latency_valid", params_valid, !e.is_err);
      checkOutput("final_latency_err", err, e.is_err);
      checkOutput("ready_after_final", s_ready, 1'b0);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL result_timeout: got %0d pending results expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    checkOutput("ready_during_clear", s_ready, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_valid", params_valid, 1'b0);
    checkOutput("idle_err", err, 1'b0);
    checkOutput("idle_ready", s_ready, 1'b1);
  endtask

  task automatic checkResetState(input string name);
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    checkArrays(name);
    checkOutput({name, "_valid"}, params_valid, 1'b0);
    checkOutput({name, "_err"}, err, 1'b0);
    checkOutput({name, "_busy"}, busy, 1'b0);
    checkOutput({name, "_ready"}, s_ready, 1'b1);
  endtask

  task automatic randomStim();
    for (int i = 0; i < N; i++) stim[i] = 8'($urandom);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int lastAt;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    clear   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetState("reset");

    $display("[TB] back-to-back load of 1..9");
    for (int i = 0; i < N; i++) stim[i] = 8'(i + 1);
    applyStimulus(N, N - 1, 0);
    waitDrain();
    checkOutput("w00_value", weights_o[0][0], 8'd1);
    checkOutput("b2_value", biases_o[2], 8'd9);
    pulseClear();
    checkArrays("hold_after_clear");

    $display("[TB] gapped load of 1..9");
    applyStimulus(N, N - 1, 40);
    waitDrain();
    pulseClear();

    $display("[TB] early s_last on word 5");
    randomStim();
    applyStimulus(5, 4, 0);
    waitDrain();
    checkOutput("w11_after_early_last", weights_o[1][1], stim[4]);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("ready_in_err", s_ready, 1'b0);
      checkOutput("err_held", err, 1'b1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    #1;
    checkArrays("hold_in_err");
    pulseClear();
    randomStim();
    applyStimulus(N, N - 1, 20);
    waitDrain();
    pulseClear();

    $display("[TB] final word without s_last");
    randomStim();
    applyStimulus(N, -1, 0);
    waitDrain();
    checkOutput("no_last_valid", params_valid, 1'b0);
    pulseClear();

    $display("[TB] clear mid-load with s_valid high");
    randomStim();
    applyStimulus(3, N - 1, 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hAA;
    clear   = 1'b1;
    #1;
    checkOutput("ready_clear_priority", s_ready, 1'b0);
    @(negedge clk);
    clear   = 1'b0;
    s_valid = 1'b0;
    #1;
    checkOutput("busy_after_mid_clear", busy, 1'b0);
    checkArrays("arrays_after_mid_clear");
    randomStim();
    applyStimulus(N, N - 1, 0);
    waitDrain();
    pulseClear();

    $display("[TB] reset after word 4, then 0xFF reload");
    randomStim();
    applyStimulus(4, N - 1, 0);
    @(negedge clk);
    rst     = 1'b1;
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h33;
    @(negedge clk);
    rst     = 1'b0;
    clear   = 1'b0;
    s_valid = 1'b0;
    #1;
    checkResetState("mid_reset");
    for (int i = 0; i < N; i++) stim[i] = 8'hFF;
    applyStimulus(N, N - 1, 0);
    waitDrain();
    pulseClear();

    $display("[TB] random loads");
    for (int t = 0; t < 10; t++) begin
      randomStim();
      lastAt = int'($urandom_range(N)) - 1;
      applyStimulus((lastAt < 0) ? N : lastAt + 1, lastAt, 25);
      waitDrain();
      pulseClear();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
